// File: rtl/sipo_rx.sv
// Framed serial-in / parallel-out receiver: start bit, WIDTH data bits LSB-first,
// optional even-parity bit (build with SIPO_RX_PARITY_CHECK_EN), stop bit, one-word holding register.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   po_q, po_d;
    logic               po_valid_q, po_valid_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
    logic               par_bad;
    logic               good_stop;
    logic               xfer;
    logic               load;
    logic               drop;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!si) state_d = S_DATA;
`ifdef SIPO_RX_PARITY_CHECK_EN
            S_DATA:   if (cnt_q == LAST) state_d = S_PARITY;
`else
            S_DATA:   if (cnt_q == LAST) state_d = S_STOP;
`endif
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = si ? S_IDLE : S_BREAK;
            S_BREAK:  if (si) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath: shift capture, holding register and handshake
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (state_q == S_IDLE && !si) begin
            cnt_d = '0;
        end
        if (state_q == S_DATA) begin
            shreg_d[cnt_q] = si;
            // Hold on the last bit so the counter never wraps inside a frame.
            if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
        end

        good_stop   = (state_q == S_STOP) && si && !par_bad;
        xfer        = po_valid_q && po_ready;
        load        = good_stop && (!po_valid_q || po_ready);
        drop        = good_stop && po_valid_q && !po_ready;
        po_d        = load ? shreg_q : po_q;
        po_valid_d  = load || (po_valid_q && !po_ready);
        overrun_d   = drop || (overrun_q && !xfer);
        frame_err_d = (state_q == S_STOP) && !si;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            po_q        <= '0;
            po_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            po_q        <= po_d;
            po_valid_q  <= po_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SIPO_RX_PARITY_CHECK_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;

    // The bad-parity flag spans PARITY..STOP so the word is discarded at the stop bit.
    always_comb begin
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
        if (state_q == S_IDLE && !si) begin
            par_bad_d = 1'b0;
        end
        if (state_q == S_PARITY) begin
            par_bad_d    = (^shreg_q) ^ si;
            parity_err_d = (^shreg_q) ^ si;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign par_bad    = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign po        = po_q;
    assign po_valid  = po_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus randomized frames, compared each
// cycle against a frame-level reference model of the holding register and status pulses.
module tb_sipo_rx;

    localparam int W = 4;

    typedef enum int {K_IDLE, K_START, K_DATA, K_PAR, K_STOP, K_BRK} kind_e;

    logic         clk;
    logic         reset;
    logic         si;
    logic [W-1:0] po;
    logic         po_valid;
    logic         po_ready;
    logic         busy;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovr;
    logic         m_ferr;
    logic         m_perr;
    logic         m_busy;
    logic         m_par_bad;

    sipo_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .si         (si),
        .po         (po),
        .po_valid   (po_valid),
        .po_ready   (po_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data    = '0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_ferr    = 1'b0;
        m_perr    = 1'b0;
        m_busy    = 1'b0;
        m_par_bad = 1'b0;
    endtask

    task automatic check_outputs();
        check("po",         32'(po),         32'(m_data));
        check("po_valid",   32'(po_valid),   32'(m_valid));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("frame_err",  32'(frame_err),  32'(m_ferr));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("busy",       32'(busy),       32'(m_busy));
    endtask

    // One bit time: drive inputs, let the DUT sample, advance the model, check at the falling edge.
    task automatic drive(input logic s, input logic rdy, input kind_e kind, input logic [W-1:0] word);
        logic xfer, load, drop;
        si       = s;
        po_ready = rdy;
        @(posedge clk);
        xfer = m_valid && rdy;
        load = 1'b0;
        drop = 1'b0;
        if (kind == K_START) m_par_bad = 1'b0;
        if (kind == K_STOP && s && !m_par_bad) begin
            if (!m_valid || rdy) load = 1'b1;
            else                 drop = 1'b1;
        end
        m_perr = (kind == K_PAR) && ((^word) ^ s);
        if (kind == K_PAR) m_par_bad = (^word) ^ s;
        m_ferr = (kind == K_STOP) && !s;
        if (load) m_data = word;
        m_valid = load ? 1'b1 : (xfer ? 1'b0 : m_valid);
        m_ovr   = drop ? 1'b1 : (xfer ? 1'b0 : m_ovr);
        case (kind)
            K_START, K_DATA, K_PAR: m_busy = 1'b1;
            K_STOP, K_BRK:          m_busy = !s;
            default:                m_busy = 1'b0;
        endcase
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic rdy_val(input int sel);
        if (sel == 1) return 1'b1;
        if (sel == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // rdy_sel: 0 never ready, 1 always ready, 2 random, 3 ready only on the stop bit
    task automatic send_frame(input logic [W-1:0] w, input logic par_flip, input logic stop_bit,
                              input int rdy_sel);
        drive(1'b0, rdy_val(rdy_sel), K_START, w);
        for (int i = 0; i < W; i++) drive(w[i], rdy_val(rdy_sel), K_DATA, w);
`ifdef SIPO_RX_PARITY_CHECK_EN
        drive((^w) ^ par_flip, rdy_val(rdy_sel), K_PAR, w);
`endif
        drive(stop_bit, (rdy_sel == 3) ? 1'b1 : rdy_val(rdy_sel), K_STOP, w);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b1, rdy, K_IDLE, '0);
    endtask

    initial begin
        reset    = 1'b0;
        si       = 1'b1;
        po_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        idle(2, 1'b0);

        // Basic receive of 4'b1101 with the consumer always ready
        send_frame(4'b1101, 1'b0, 1'b1, 1);
        check("basic_po", 32'(po), 32'hD);
        idle(1, 1'b1);
        check("basic_drop_valid", 32'(po_valid), 32'h0);
        idle(1, 1'b1);

        // Backpressure: second word is dropped and overrun latches
        send_frame(4'h3, 1'b0, 1'b1, 0);
        send_frame(4'hA, 1'b0, 1'b1, 0);
        check("ovr_po_held", 32'(po), 32'h3);
        check("ovr_flag", 32'(overrun), 32'h1);
        idle(1, 1'b1);
        check("ovr_cleared", 32'(overrun), 32'h0);
        idle(1, 1'b0);

        // Simultaneous consume and load
        send_frame(4'h5, 1'b0, 1'b1, 0);
        idle(1, 1'b0);
        send_frame(4'h9, 1'b0, 1'b1, 3);
        check("swap_po", 32'(po), 32'h9);
        check("swap_valid", 32'(po_valid), 32'h1);
        idle(2, 1'b1);

        // Framing error followed by a held-low line
        send_frame(4'hF, 1'b0, 1'b0, 0);
        check("ferr_pulse", 32'(frame_err), 32'h1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, K_BRK, '0);
        drive(1'b1, 1'b0, K_BRK, '0);
        idle(2, 1'b0);

        // Reset in the middle of a frame
        drive(1'b0, 1'b0, K_START, 4'h6);
        drive(1'b0, 1'b0, K_DATA, 4'h6);
        drive(1'b1, 1'b0, K_DATA, 4'h6);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        si    = 1'b1;
        reset = 1'b1;
        idle(1, 1'b0);
        send_frame(4'hC, 1'b0, 1'b1, 0);
        check("post_reset_po", 32'(po), 32'hC);
        idle(1, 1'b1);

`ifdef SIPO_RX_PARITY_CHECK_EN
        send_frame(4'b0111, 1'b0, 1'b1, 0);
        check("par_good_po", 32'(po), 32'h7);
        idle(1, 1'b1);
        send_frame(4'b0111, 1'b1, 1'b1, 1);
        check("par_bad_valid", 32'(po_valid), 32'h0);
        idle(1, 1'b1);
`endif

        // Randomized frames: data, gaps, backpressure, parity and framing faults
        for (int f = 0; f < 80; f++) begin
            logic [W-1:0] w;
            logic         flip, stop_bit;
            w        = W'($urandom);
            flip     = ($urandom_range(0, 5) == 0);
            stop_bit = ($urandom_range(0, 7) != 0);
            send_frame(w, flip, stop_bit, 2);
            if (!stop_bit) begin
                int n_low;
                n_low = $urandom_range(0, 3);
                for (int i = 0; i < n_low; i++) drive(1'b0, rdy_val(2), K_BRK, '0);
                drive(1'b1, rdy_val(2), K_BRK, '0);
            end
            idle($urandom_range(0, 2), rdy_val(2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
